trophy_spawner: RTL and testbench
=================================

TROPHY_SPAWNER -- requirements
Module: trophy_spawner

Interface
REQ-001 Parameter ROWS, default 24, number of maze cell rows (20 px cells on 480 lines).
REQ-002 Parameter COLS, default 32, number of maze cell columns (20 px cells on 640 px).
REQ-003 Parameter MAX_TRIES, default 255, candidate attempts allowed per trophy before that trophy is abandoned.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse requesting a new placement round.
REQ-007 seed  in  16  LFSR seed, sampled on the start cycle.
REQ-008 player_r, player_c  in  5 each  current character cell.
REQ-009 cell_req  out  1  registered maze-cell query request.
REQ-010 cell_r, cell_c  out  5 each  queried cell; stable while cell_req is high.
REQ-011 cell_ack  in  1  query response strobe.
REQ-012 cell_open  in  1  1 means the cell has no wall; valid only when cell_ack is high.
REQ-013 trophy_r, trophy_c  out  15 each  packed positions; trophy i is at bits [5i+4:5i].
REQ-014 trophy_active  out  3  bit i high means trophy i is placed and not yet collected.
REQ-015 place_fail  out  3  bit i high means trophy i was abandoned after MAX_TRIES attempts.
REQ-016 busy  out  1  high while a placement round is in progress.
REQ-017 done  out  1  one-cycle pulse when a round ends.
REQ-018 all_collected  out  1  one-cycle pulse when the last active trophy is collected.

Function
REQ-019 The state machine SHALL have the states IDLE, GEN and QUERY; busy is high in GEN and QUERY.
REQ-020 The LFSR SHALL be a 16-bit Fibonacci register with taps 16,14,13,11; a seed of 0 loads 16'hACE1 instead.
REQ-021 In IDLE, start SHALL do the following on the next edge: load the LFSR, set idx=0, set try_cnt=0, clear trophy_active and place_fail, and move to GEN.
REQ-022 In GEN, the candidate SHALL be row=lfsr[4:0] and col=lfsr[12:8], taken from the current LFSR value.
REQ-023 In GEN, the LFSR SHALL step once and try_cnt SHALL increment.
REQ-024 In GEN, if row>=ROWS or col>=COLS, the FSM SHALL stay in GEN; this counts as a failed try.
REQ-025 Otherwise GEN SHALL register the candidate into cell_r/cell_c, set cell_req=1 and move to QUERY.
REQ-026 In QUERY, cell_req SHALL stay high until cell_ack is sampled high; cell_req deasserts on the following edge.
REQ-027 On an accepting ack, the candidate SHALL be written to slot idx, trophy_active[idx] set, idx incremented and try_cnt cleared.
REQ-028 An ack is accepting when cell_open=1, the candidate differs from (player_r, player_c), and it differs from every slot j<idx whose bit is active.
REQ-029 On a rejecting ack, the FSM SHALL return to GEN.
REQ-030 When try_cnt reaches MAX_TRIES without acceptance, place_fail[idx] SHALL be set, the trophy left inactive, idx incremented and try_cnt cleared.
REQ-031 After slot 2 is resolved (placed or failed), done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-032 Minimum latency: start at cycle T gives cell_req high at T+2; an ack at T+2 gives trophy_active[0] high at T+3.
REQ-033 start SHALL be ignored while busy.
REQ-034 start in IDLE with trophies active SHALL restart the round, and active bits SHALL be cleared on that edge.
REQ-035 Collection SHALL be evaluated every cycle in IDLE only: if trophy_active[i] is set and the player is at slot i, bit i clears on the next edge.
REQ-036 Several trophies may clear in the same edge.
REQ-037 all_collected SHALL pulse for one cycle on the edge where trophy_active goes from nonzero to 0 through collection; it does not pulse through restart or reset.
REQ-038 If cell_ack arrives while cell_req is low, it SHALL be ignored.
REQ-039 try_cnt SHALL be 8 bits and saturate at MAX_TRIES.

Reset
REQ-040 On rst, the FSM SHALL go to IDLE and the LFSR SHALL load 16'hACE1.
REQ-041 On rst, all outputs (cell_req, cell_r, cell_c, trophy_r, trophy_c, trophy_active, place_fail, busy, done, all_collected) SHALL be 0.
REQ-042 rst SHALL take priority over start, cell_ack and collection in the same cycle.
REQ-043 rst mid-round SHALL abort the round with no done pulse; a late cell_ack is ignored.

Verification
REQ-044 Stimulus: seed=0, start, cell model always open with ack one cycle after req, player at (0,0). Response: first query is cell_r=1, cell_c=12 (from 16'hACE1); done pulses; trophy_active=3'b111; place_fail=0.
REQ-045 Stimulus: cell model reports the first candidate closed. Response: cell_req drops, GEN runs, a new candidate is queried, and no slot is written for the rejected cell.
REQ-046 Stimulus: cell model always closed, MAX_TRIES=4. Response: place_fail=3'b111, trophy_active=0, done pulses after 12 tries, and all_collected stays 0.
REQ-047 Stimulus: after a full placement, drive the player to each trophy position in turn. Response: the matching bit clears one cycle later, and all_collected pulses exactly once after the third trophy.
REQ-048 Stimulus: assert rst while in QUERY, then ack. Response: all outputs are 0 and no done pulse occurs.
REQ-049 Stimulus: a second start while busy. Response: it is ignored and the round completes unchanged.

Source files
------------

// File: rtl/trophy_spawner.sv
// Trophy spawner: places three trophies on open maze cells that avoid the
// player and each other. Candidates come from a 16-bit LFSR, and each
// candidate is checked through a request/acknowledge maze-cell query.
// In IDLE, a trophy is collected when the player stands on it.
module trophy_spawner #(
   parameter int ROWS      = 24,
   parameter int COLS      = 32,
   parameter int MAX_TRIES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] seed,
   input  logic [4:0]  player_r,
   input  logic [4:0]  player_c,
   output logic        cell_req,
   output logic [4:0]  cell_r,
   output logic [4:0]  cell_c,
   input  logic        cell_ack,
   input  logic        cell_open,
   output logic [14:0] trophy_r,
   output logic [14:0] trophy_c,
   output logic [2:0]  trophy_active,
   output logic [2:0]  place_fail,
   output logic        busy,
   output logic        done,
   output logic        all_collected
);

   typedef enum logic [1:0] {IDLE, GEN, QUERY} state_t;

   localparam logic [7:0]  MAX_T     = 8'(MAX_TRIES);
   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   state_t      state, state_nx;
   logic [15:0] lfsr;
   logic [1:0]  idx;
   logic [7:0]  try_cnt;
   logic [4:0]  cand_r, cand_c;
   logic        in_range, exhausted, last_slot, dup, accept;
   logic [2:0]  collect;

   // Fibonacci LFSR with taps 16,14,13,11, shifting toward the MSB
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // An all-zero seed would lock the LFSR, so it is replaced by the default
   function automatic logic [15:0] seed_fix(input logic [15:0] s);
      return (s == 16'd0) ? LFSR_INIT : s;
   endfunction

   assign busy = (state != IDLE);

   // Candidate decode, acceptance test and per-slot collection matches
   always_comb begin
      cand_r    = lfsr[4:0];
      cand_c    = lfsr[12:8];
      in_range  = (int'(cand_r) < ROWS) && (int'(cand_c) < COLS);
      exhausted = (try_cnt >= MAX_T);
      last_slot = (idx == 2'd2);
      dup       = 1'b0;
      collect   = '0;
      for (int j = 0; j < 3; j++) begin
         if ((j < int'(idx)) && trophy_active[j] &&
             (trophy_r[5*j +: 5] == cell_r) && (trophy_c[5*j +: 5] == cell_c))
            dup = 1'b1;
         collect[j] = trophy_active[j] &&
                      (trophy_r[5*j +: 5] == player_r) && (trophy_c[5*j +: 5] == player_c);
      end
      accept = cell_open && !((cell_r == player_r) && (cell_c == player_c)) && !dup;
   end

   // Next-state logic for the placement sequencer
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = GEN;
         GEN: begin
            if (exhausted)     state_nx = last_slot ? IDLE : GEN;
            else if (in_range) state_nx = QUERY;
         end
         QUERY: begin
            if (cell_ack) begin
               if (accept) state_nx = last_slot ? IDLE : GEN;
               else        state_nx = GEN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // LFSR, counters, query port, trophy slots and status pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr          <= LFSR_INIT;
         idx           <= '0;
         try_cnt       <= '0;
         cell_req      <= 1'b0;
         cell_r        <= '0;
         cell_c        <= '0;
         trophy_r      <= '0;
         trophy_c      <= '0;
         trophy_active <= '0;
         place_fail    <= '0;
         done          <= 1'b0;
         all_collected <= 1'b0;
      end else begin
         done          <= 1'b0;
         all_collected <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr          <= seed_fix(seed);
                  idx           <= '0;
                  try_cnt       <= '0;
                  trophy_active <= '0;
                  place_fail    <= '0;
               end else if (|collect) begin
                  trophy_active <= trophy_active & ~collect;
                  all_collected <= ((trophy_active & ~collect) == 3'b000);
               end
            end
            GEN: begin
               if (exhausted) begin
                  // Out of attempts: abandon this slot without consuming a candidate
                  place_fail[idx] <= 1'b1;
                  idx             <= idx + 2'd1;
                  try_cnt         <= '0;
                  done            <= last_slot;
               end else begin
                  lfsr    <= lfsr_step(lfsr);
                  try_cnt <= try_cnt + 8'd1;
                  if (in_range) begin
                     cell_r   <= cand_r;
                     cell_c   <= cand_c;
                     cell_req <= 1'b1;
                  end
               end
            end
            QUERY: begin
               if (cell_ack) begin
                  cell_req <= 1'b0;
                  if (accept) begin
                     trophy_r[5*idx +: 5] <= cell_r;
                     trophy_c[5*idx +: 5] <= cell_c;
                     trophy_active[idx]   <= 1'b1;
                     idx                  <= idx + 2'd1;
                     try_cnt              <= '0;
                     done                 <= last_slot;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_trophy_spawner.sv
// Self-checking bench for trophy_spawner. A behavioural model replays the
// placement rules on a software LFSR and a random wall map.
module tb_trophy_spawner;
   localparam int ROWS = 24, COLS = 32, MT = 255, MT4 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, start4 = 1'b0;
   logic [15:0] seed = '0;
   logic [4:0]  player_r = '0, player_c = '0;
   logic        cell_req, cell_ack = 1'b0, cell_open = 1'b1;
   logic [4:0]  cell_r, cell_c;
   logic [14:0] trophy_r, trophy_c;
   logic [2:0]  trophy_active, place_fail;
   logic        busy, done, all_collected;
   logic        cell_req4, cell_ack4 = 1'b0, cell_open4 = 1'b0;
   logic [4:0]  cell_r4, cell_c4;
   logic [14:0] trophy_r4, trophy_c4;
   logic [2:0]  trophy_active4, place_fail4;
   logic        busy4, done4, all_collected4;

   int checks = 0, errors = 0;
   bit open_map [32][32];
   int ack_delay = 1, age = 0;
   bit ack_en = 1'b1, force_ack = 1'b0;
   int q_r[$], q_c[$];
   int q4_n = 0;
   int done_cnt = 0, ac_cnt = 0, done4_cnt = 0, ac4_cnt = 0;
   logic [14:0] m_r, m_c;
   logic [2:0]  m_act, m_fail;
   int m_qr[$], m_qc[$];

   trophy_spawner #(.ROWS(ROWS), .COLS(COLS), .MAX_TRIES(MT)) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed),
      .player_r(player_r), .player_c(player_c),
      .cell_req(cell_req), .cell_r(cell_r), .cell_c(cell_c),
      .cell_ack(cell_ack), .cell_open(cell_open),
      .trophy_r(trophy_r), .trophy_c(trophy_c),
      .trophy_active(trophy_active), .place_fail(place_fail),
      .busy(busy), .done(done), .all_collected(all_collected));

   trophy_spawner #(.ROWS(ROWS), .COLS(COLS), .MAX_TRIES(MT4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .seed(seed),
      .player_r(player_r), .player_c(player_c),
      .cell_req(cell_req4), .cell_r(cell_r4), .cell_c(cell_c4),
      .cell_ack(cell_ack4), .cell_open(cell_open4),
      .trophy_r(trophy_r4), .trophy_c(trophy_c4),
      .trophy_active(trophy_active4), .place_fail(place_fail4),
      .busy(busy4), .done(done4), .all_collected(all_collected4));

   always #5 clk = ~clk;

   // Maze model for the main DUT: acks ack_delay cycles after req and logs queries
   always @(negedge clk) begin
      if (!ack_en) begin
         cell_ack = force_ack; cell_open = 1'b1; age = 0;
      end else if (!cell_req) begin
         cell_ack = 1'b0; age = 0;
      end else begin
         if (age == ack_delay) begin
            cell_ack  = 1'b1;
            cell_open = open_map[cell_r][cell_c];
            q_r.push_back(int'(cell_r));
            q_c.push_back(int'(cell_c));
         end else cell_ack = 1'b0;
         age++;
      end
   end

   // Maze model for the small-budget DUT: every cell is a wall
   always @(negedge clk) begin
      if (cell_req4 && !cell_ack4) begin cell_ack4 = 1'b1; q4_n++; end
      else cell_ack4 = 1'b0;
      cell_open4 = 1'b0;
   end

   // Pulse counters
   always @(posedge clk) begin
      if (done) done_cnt++;
      if (all_collected) ac_cnt++;
      if (done4) done4_cnt++;
      if (all_collected4) ac4_cnt++;
   end

   function automatic logic [15:0] ref_step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   // Reference placement: per trophy, draw up to max_tries candidates
   task automatic model_round(input logic [15:0] sd, input int max_tries, input bit closed);
      logic [15:0] l;
      int tries, r, c;
      bit placed, dupl;
      m_r = '0; m_c = '0; m_act = '0; m_fail = '0;
      m_qr.delete(); m_qc.delete();
      l = (sd == 16'd0) ? 16'hACE1 : sd;
      for (int i = 0; i < 3; i++) begin
         tries = 0; placed = 0;
         while (!placed && tries < max_tries) begin
            r = int'(l[4:0]); c = int'(l[12:8]);
            l = ref_step(l); tries++;
            if (r < ROWS && c < COLS) begin
               m_qr.push_back(r); m_qc.push_back(c);
               dupl = 0;
               for (int j = 0; j < i; j++)
                  if (m_act[j] && int'(m_r[5*j +: 5]) == r && int'(m_c[5*j +: 5]) == c) dupl = 1;
               if (!closed && open_map[r][c] && !(r == int'(player_r) && c == int'(player_c)) && !dupl) begin
                  m_r[5*i +: 5] = 5'(r); m_c[5*i +: 5] = 5'(c);
                  m_act[i] = 1'b1; placed = 1;
               end
            end
         end
         if (!placed) m_fail[i] = 1'b1;
      end
   endtask

   function automatic bit queries_match();
      if (q_r.size() != m_qr.size()) return 0;
      foreach (q_r[k]) if (q_r[k] != m_qr[k] || q_c[k] != m_qc[k]) return 0;
      return 1;
   endfunction

   task automatic set_map(input int mode);
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++)
            open_map[r][c] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 6);
   endtask

   task automatic do_start(input logic [15:0] sd);
      q_r.delete(); q_c.delete();
      @(negedge clk); seed = sd; start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(output bit got, input int budget);
      got = 0;
      for (int k = 0; k < budget && !got; k++) begin
         @(negedge clk);
         if (done) got = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; start4 = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++;
      if ({cell_req, cell_r, cell_c, trophy_r, trophy_c, trophy_active, place_fail, done, all_collected} !== '0) begin
         errors++; $display("FAIL reset_outputs: got req=%b r=%0d c=%0d tr=%h tc=%h act=%b fail=%b want all 0",
                            cell_req, cell_r, cell_c, trophy_r, trophy_c, trophy_active, place_fail);
      end
      checks++;
      if ({cell_req4, busy4, trophy_active4, place_fail4, trophy_r4, trophy_c4, done4} !== '0) begin
         errors++; $display("FAIL reset_outputs4: got req=%b busy=%b act=%b fail=%b want 0", cell_req4, busy4, trophy_active4, place_fail4);
      end
      start = 1'b0; start4 = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit got;
      set_map(0); ack_delay = 1; player_r = 5'd0; player_c = 5'd0;
      model_round(16'd0, MT, 0);
      do_start(16'd0);
      wait_done(got, 500);
      checks++;
      if (!got) begin errors++; $display("FAIL basic_done: got no done want pulse"); end
      checks++;
      if (q_r.size() == 0 || q_r[0] != 1 || q_c[0] != 12) begin
         errors++; $display("FAIL basic_first_query: got %0d queries (first %0d,%0d) want (1,12)",
                            q_r.size(), (q_r.size() > 0) ? q_r[0] : -1, (q_c.size() > 0) ? q_c[0] : -1);
      end
      checks++;
      if (trophy_active !== 3'b111 || place_fail !== 3'b000) begin
         errors++; $display("FAIL basic_status: got act=%b fail=%b want 111/000", trophy_active, place_fail);
      end
      checks++;
      if (trophy_r !== m_r || trophy_c !== m_c || !queries_match()) begin
         errors++; $display("FAIL basic_positions: got r=%h c=%h nq=%0d want r=%h c=%h nq=%0d",
                            trophy_r, trophy_c, q_r.size(), m_r, m_c, m_qr.size());
      end
   endtask

   task automatic test_latency();
      bit got;
      set_map(0); ack_delay = 0; player_r = 5'd0; player_c = 5'd0;
      do_start(16'd0);
      checks++;
      if (cell_req !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL lat_t1: got req=%b busy=%b want 0/1", cell_req, busy);
      end
      @(negedge clk);
      checks++;
      if (cell_req !== 1'b1 || cell_r !== 5'd1 || cell_c !== 5'd12) begin
         errors++; $display("FAIL lat_t2_req: got req=%b (%0d,%0d) want 1 (1,12)", cell_req, cell_r, cell_c);
      end
      @(negedge clk);
      checks++;
      if (trophy_active !== 3'b001 || cell_req !== 1'b0) begin
         errors++; $display("FAIL lat_t3_active: got act=%b req=%b want 001/0", trophy_active, cell_req);
      end
      wait_done(got, 500);
      checks++;
      if (!got || trophy_active !== 3'b111) begin
         errors++; $display("FAIL lat_round: got done=%b act=%b want 1/111", got, trophy_active);
      end
   endtask

   task automatic test_reject();
      bit got;
      set_map(0); open_map[1][12] = 1'b0; ack_delay = 1; player_r = 5'd0; player_c = 5'd0;
      model_round(16'd0, MT, 0);
      do_start(16'd0);
      wait_done(got, 500);
      checks++;
      if (!got || q_r.size() < 2 || q_r[0] != 1 || q_c[0] != 12 || (q_r[1] == 1 && q_c[1] == 12)) begin
         errors++; $display("FAIL reject_requery: got done=%b nq=%0d want requery after (1,12)", got, q_r.size());
      end
      checks++;
      if (trophy_r[4:0] === 5'd1 && trophy_c[4:0] === 5'd12) begin
         errors++; $display("FAIL reject_slot0: got (%0d,%0d) want not (1,12)", trophy_r[4:0], trophy_c[4:0]);
      end
      checks++;
      if (trophy_r !== m_r || trophy_c !== m_c || trophy_active !== m_act || !queries_match()) begin
         errors++; $display("FAIL reject_model: got r=%h c=%h act=%b want r=%h c=%h act=%b",
                            trophy_r, trophy_c, trophy_active, m_r, m_c, m_act);
      end
   endtask

   task automatic test_random();
      bit got;
      logic [15:0] sd;
      for (int n = 0; n < 6; n++) begin
         set_map(2);
         ack_delay = $urandom_range(0, 3);
         player_r = 5'($urandom_range(0, 23)); player_c = 5'($urandom_range(0, 31));
         sd = 16'($urandom);
         model_round(sd, MT, 0);
         do_start(sd);
         wait_done(got, 8000);
         checks++;
         if (!got || trophy_r !== m_r || trophy_c !== m_c || trophy_active !== m_act ||
             place_fail !== m_fail || !queries_match()) begin
            errors++; $display("FAIL random_round%0d: got done=%b r=%h c=%h act=%b fail=%b nq=%0d want r=%h c=%h act=%b fail=%b nq=%0d",
                               n, got, trophy_r, trophy_c, trophy_active, place_fail, q_r.size(),
                               m_r, m_c, m_act, m_fail, m_qr.size());
         end
      end
   endtask

   task automatic test_collect();
      bit got;
      int ac0;
      logic [2:0] exp_act;
      set_map(0); ack_delay = 1; player_r = 5'd31; player_c = 5'd31;
      model_round(16'h1D3B, MT, 0);
      do_start(16'h1D3B);
      wait_done(got, 500);
      ac0 = ac_cnt; exp_act = m_act;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         player_r = m_r[5*i +: 5]; player_c = m_c[5*i +: 5];
         @(negedge clk);
         exp_act[i] = 1'b0;
         checks++;
         if (trophy_active !== exp_act || all_collected !== (exp_act == 3'b000)) begin
            errors++; $display("FAIL collect_%0d: got act=%b allc=%b want act=%b allc=%b",
                               i, trophy_active, all_collected, exp_act, exp_act == 3'b000);
         end
      end
      player_r = 5'd31; player_c = 5'd31;
      repeat (3) @(negedge clk);
      checks++;
      if (ac_cnt != ac0 + 1) begin
         errors++; $display("FAIL collect_pulses: got %0d want 1", ac_cnt - ac0);
      end
   endtask

   task automatic test_restart();
      bit got;
      int ac0;
      set_map(0); ack_delay = 0; player_r = 5'd31; player_c = 5'd31;
      do_start(16'h4242);
      wait_done(got, 500);
      ac0 = ac_cnt;
      model_round(16'hBEEF, MT, 0);
      do_start(16'hBEEF);
      checks++;
      if (trophy_active !== 3'b000 || busy !== 1'b1) begin
         errors++; $display("FAIL restart_clear: got act=%b busy=%b want 000/1", trophy_active, busy);
      end
      wait_done(got, 500);
      repeat (2) @(negedge clk);
      checks++;
      if (!got || trophy_r !== m_r || trophy_c !== m_c || trophy_active !== m_act || ac_cnt != ac0) begin
         errors++; $display("FAIL restart_round: got done=%b act=%b r=%h allc=%0d want act=%b r=%h allc=0",
                            got, trophy_active, trophy_r, ac_cnt - ac0, m_act, m_r);
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      int d0;
      set_map(2); ack_delay = 1; player_r = 5'd3; player_c = 5'd7;
      model_round(16'h9C21, MT, 0);
      d0 = done_cnt;
      do_start(16'h9C21);
      @(negedge clk); seed = 16'h0F0F; start = 1'b1;
      @(negedge clk); start = 1'b0; seed = '0;
      wait_done(got, 8000);
      repeat (3) @(negedge clk);
      checks++;
      if (!got || trophy_r !== m_r || trophy_c !== m_c || trophy_active !== m_act || place_fail !== m_fail) begin
         errors++; $display("FAIL b2b_result: got r=%h c=%h act=%b fail=%b want r=%h c=%h act=%b fail=%b",
                            trophy_r, trophy_c, trophy_active, place_fail, m_r, m_c, m_act, m_fail);
      end
      checks++;
      if (done_cnt != d0 + 1 || busy !== 1'b0) begin
         errors++; $display("FAIL b2b_done_count: got %0d busy=%b want 1/0", done_cnt - d0, busy);
      end
   endtask

   task automatic test_fail();
      bit got;
      int d0;
      logic [15:0] sd;
      sd = 16'($urandom);
      model_round(sd, MT4, 1);
      q4_n = 0; d0 = done4_cnt;
      @(negedge clk); seed = sd; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (done4) got = 1;
      end
      checks++;
      if (!got || place_fail4 !== 3'b111 || trophy_active4 !== 3'b000) begin
         errors++; $display("FAIL fail_status: got done=%b fail=%b act=%b want 1/111/000", got, place_fail4, trophy_active4);
      end
      checks++;
      if (q4_n != m_qr.size()) begin
         errors++; $display("FAIL fail_queries: got %0d want %0d", q4_n, m_qr.size());
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done4_cnt != d0 + 1 || ac4_cnt != 0) begin
         errors++; $display("FAIL fail_pulses: got done=%0d allc=%0d want 1/0", done4_cnt - d0, ac4_cnt);
      end
   endtask

   task automatic test_rst_query();
      bit got;
      int d0;
      set_map(0); ack_en = 1'b0; force_ack = 1'b0; player_r = 5'd31; player_c = 5'd31;
      do_start(16'h5A5A);
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         if (cell_req) got = 1;
         else @(negedge clk);
      end
      checks++;
      if (!got) begin errors++; $display("FAIL rstq_req: got no cell_req want 1"); end
      d0 = done_cnt;
      rst = 1'b1; force_ack = 1'b1;
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      force_ack = 1'b0;
      checks++;
      if ({cell_req, cell_r, cell_c, trophy_r, trophy_c, trophy_active, place_fail, busy, done, all_collected} !== '0) begin
         errors++; $display("FAIL rstq_outputs: got req=%b busy=%b act=%b fail=%b tr=%h want all 0",
                            cell_req, busy, trophy_active, place_fail, trophy_r);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin errors++; $display("FAIL rstq_done: got %0d pulses want 0", done_cnt - d0); end
      ack_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_latency();
      test_reject();
      test_random();
      test_collect();
      test_restart();
      test_back_to_back();
      test_fail();
      test_rst_query();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
